// File: rtl/accum_pkg.sv
// accum_pkg: shared FSM encodings and widths
// for the accumulating run controller.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_t;

  // N is capped at 255, so 8 bits always hold
  // the operand count of a run.
  localparam int CNT_W = 8;

endpackage

// File: rtl/accum_add.sv
// accum_add: WIDTH-bit adder with carry out.
// ACCUM_SAT_EN clamps a carrying sum to all-ones.
module accum_add #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  // widened add; carry drives ovf and saturation
  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
`ifdef ACCUM_SAT_EN
    sum   = carry ? '1 : full[WIDTH-1:0];
`else
    sum   = full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/accum_ctrl.sv
// accum_ctrl: sums N operands per run, emits one
// q_ld strobe with the result. Option: ACCUM_SAT_EN.
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             q_ld,
  output logic [WIDTH-1:0] q_d,
  output logic             busy,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             last;

  accum_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .a    (acc),
    .b    (in_data),
    .sum  (sum),
    .carry(carry)
  );

  assign hs   = in_valid && in_ready;
  assign last = (cnt == LAST);

  // next state and state-decoded strobes
  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    q_ld     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (hs && last) nxt = OUT;
      end
      OUT: begin
        busy = 1'b1;
        q_ld = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // accumulator, counter, result and sticky ovf
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      q_d <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (hs) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      if (carry) ovf <= 1'b1;
      if (last)  q_d <= sum;
    end
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// tb_accum_ctrl: N=4 and N=1 instances against an
// operand-list model, scripted cases then random traffic.
module tb_accum_ctrl;

`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] st;
  logic [1:0] vl;
  logic [7:0] dt [2];
  logic [1:0] rdy;
  logic [1:0] qld;
  logic [1:0] bsy;
  logic [1:0] ov;
  logic [7:0] qd [2];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  accum_ctrl #(.WIDTH(8), .N(4)) u4 (
    .clk(clk), .rst(rst), .start(st[0]),
    .in_valid(vl[0]), .in_data(dt[0]),
    .in_ready(rdy[0]), .q_ld(qld[0]), .q_d(qd[0]),
    .busy(bsy[0]), .ovf(ov[0])
  );

  accum_ctrl #(.WIDTH(8), .N(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]),
    .in_valid(vl[1]), .in_data(dt[1]),
    .in_ready(rdy[1]), .q_ld(qld[1]), .q_d(qd[1]),
    .busy(bsy[1]), .ovf(ov[1])
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  // behavioural model: a run is a list of operands;
  // the result is their total, wrapped or clamped
  bit acc_m  [2];
  bit emit_m [2];
  bit ovf_m  [2];
  int tot_m  [2];
  int cnt_m  [2];
  int q_m    [2];
  bit armed = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nn;
      nn = (i == 0) ? 4 : 1;
      if (rst) begin
        acc_m[i]  = 1'b0;
        emit_m[i] = 1'b0;
        ovf_m[i]  = 1'b0;
        tot_m[i]  = 0;
        cnt_m[i]  = 0;
        q_m[i]    = 0;
      end else if (emit_m[i]) begin
        emit_m[i] = 1'b0;
      end else if (acc_m[i]) begin
        if (vl[i]) begin
          tot_m[i] += int'(dt[i]);
          cnt_m[i]++;
          ovf_m[i] = (tot_m[i] > 255);
          if (cnt_m[i] == nn) begin
            if (SAT) q_m[i] = (tot_m[i] > 255) ? 255 : tot_m[i];
            else     q_m[i] = tot_m[i] % 256;
            acc_m[i]  = 1'b0;
            emit_m[i] = 1'b1;
          end
        end
      end else if (st[i]) begin
        tot_m[i] = 0;
        cnt_m[i] = 0;
        ovf_m[i] = 1'b0;
        acc_m[i] = 1'b1;
      end
    end
    armed = 1'b1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("in_ready[%0d]", i), int'(rdy[i]),
            int'(acc_m[i]));
        chk($sformatf("busy[%0d]", i), int'(bsy[i]),
            int'(acc_m[i] | emit_m[i]));
        chk($sformatf("q_ld[%0d]", i), int'(qld[i]),
            int'(emit_m[i]));
        chk($sformatf("q_d[%0d]", i), int'(qd[i]), q_m[i]);
        chk($sformatf("ovf[%0d]", i), int'(ov[i]),
            int'(ovf_m[i]));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int i);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  // holds in_valid until a handshake edge has passed
  task automatic send(input int i, input logic [7:0] d);
    bit r;
    vl[i] = 1'b1;
    dt[i] = d;
    for (int k = 0; k < 50; k++) begin
      r = rdy[i];
      @(negedge clk);
      if (r) return;
    end
    total++;
    $display("FAIL send_timeout[%0d]: got no handshake",
             i);
  endtask

  task automatic run4(input logic [7:0] a, b, c, d);
    pulse_start(0);
    send(0, a);
    send(0, b);
    send(0, c);
    send(0, d);
    vl[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    st  = '0;
    vl  = '0;
    dt[0] = '0;
    dt[1] = '0;
    cyc(2);
    rst = 1'b0;
    chk("reset_busy", int'(bsy[0]), 0);
    chk("reset_q_d", int'(qd[0]), 0);
    chk("reset_ovf", int'(ov[0]), 0);
    chk("reset_in_ready", int'(rdy[0]), 0);

    run4(8'd1, 8'd2, 8'd3, 8'd4);
    chk("seq_q_ld", int'(qld[0]), 1);
    chk("seq_q_d", int'(qd[0]), 10);
    chk("seq_ovf", int'(ov[0]), 0);
    cyc(1);
    chk("seq_busy_drop", int'(bsy[0]), 0);
    chk("seq_q_ld_once", int'(qld[0]), 0);
    chk("seq_q_d_hold", int'(qd[0]), 10);

    run4(8'd200, 8'd100, 8'd0, 8'd0);
    chk("ovf_q_d", int'(qd[0]), SAT ? 255 : 44);
    chk("ovf_flag", int'(ov[0]), 1);
    cyc(2);
    chk("ovf_sticky", int'(ov[0]), 1);

    pulse_start(0);
    chk("start_clears_ovf", int'(ov[0]), 0);
    for (int k = 0; k < 4; k++) begin
      send(0, 8'(5 + k));
      vl[0] = 1'b0;
      if (k < 3) cyc(3);
    end
    chk("gap_latency_q_ld", int'(qld[0]), 1);
    chk("gap_q_d", int'(qd[0]), 26);
    cyc(1);

    pulse_start(0);
    send(0, 8'd1);
    send(0, 8'd2);
    vl[0] = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_mid_busy", int'(bsy[0]), 0);
    chk("rst_mid_q_d", int'(qd[0]), 0);
    chk("rst_mid_q_ld", int'(qld[0]), 0);
    run4(8'd1, 8'd1, 8'd1, 8'd1);
    chk("after_rst_q_d", int'(qd[0]), 4);
    cyc(1);

    pulse_start(0);
    send(0, 8'd3);
    vl[0] = 1'b0;
    pulse_start(0);
    send(0, 8'd4);
    send(0, 8'd5);
    send(0, 8'd6);
    vl[0] = 1'b0;
    chk("start_in_load_q_ld", int'(qld[0]), 1);
    chk("start_in_load_q_d", int'(qd[0]), 18);
    cyc(1);

    pulse_start(1);
    send(1, 8'd9);
    vl[1] = 1'b0;
    chk("n1_q_ld", int'(qld[1]), 1);
    chk("n1_q_d", int'(qd[1]), 9);
    cyc(1);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 300) == 0;
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom % 6) == 0;
        vl[i] = ($urandom % 3) != 0;
        dt[i] = ($urandom % 2) ? 8'($urandom_range(150, 255))
                               : 8'($urandom % 64);
      end
      cyc(1);
    end
    rst = 1'b0;
    st  = '0;
    vl  = '0;
    cyc(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning operands summed per run; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to begin a run.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream operand is valid.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: operand, unsigned.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-009 The block SHALL have port q_ld, output, 1 bit: load strobe for the downstream result register.
REQ-010 The block SHALL have port q_d, output, WIDTH bits: result presented with q_ld.
REQ-011 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-012 The block SHALL have port ovf, output, 1 bit: overflow occurred in the current or last run.

Function
REQ-013 The block SHALL implement FSM states IDLE, LOAD, OUT.
REQ-014 In IDLE, start=1 SHALL clear the accumulator, operand counter and ovf, then enter LOAD next cycle.
REQ-015 In LOAD, in_ready SHALL be 1; in IDLE and OUT it SHALL be 0.
REQ-016 A handshake SHALL occur only when in_valid=1 and in_ready=1; the accumulator SHALL add in_data and the counter SHALL increment on that edge.
REQ-017 in_valid=0 in LOAD SHALL stall with no state change; gaps of any length SHALL be tolerated.
REQ-018 The handshake of the N-th operand SHALL move the FSM to OUT.
REQ-019 In OUT, q_ld SHALL be 1 for exactly one cycle with q_d equal to the final sum; the next state SHALL be IDLE.
REQ-020 q_d SHALL hold the last result outside OUT; q_ld SHALL be 0 outside OUT.
REQ-021 busy SHALL be 1 in LOAD and OUT and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 Addition SHALL use a WIDTH+1-bit sum; a carry out SHALL set ovf, which stays sticky until the next accepted start or reset.
REQ-024 Latency SHALL be one cycle from the N-th handshake edge to q_ld=1.
REQ-025 With N=1, one handshake SHALL go directly to OUT.

Reset
REQ-026 rst=1 SHALL force IDLE, with the accumulator, counter, q_d and ovf set to 0 and q_ld, busy and in_ready set to 0, in any state including mid-run.
REQ-027 rst SHALL take priority over start and over handshakes in the same cycle; no partial result SHALL be emitted.

Configuration
REQ-028 When macro ACCUM_SAT_EN is defined, an add that carries out SHALL clamp the accumulator to all-ones (2^WIDTH-1) for the rest of the run, and ovf SHALL still be set.
REQ-029 When ACCUM_SAT_EN is undefined, the accumulator SHALL wrap modulo 2^WIDTH.

Structure
REQ-030 A shared package accum_pkg SHALL hold the FSM state encodings (IDLE=2'd0, LOAD=2'd1, OUT=2'd2) and the counter-width constant.
REQ-031 The adder with carry, and saturation when enabled, SHALL be a sub-module accum_add; the FSM, counter and output register SHALL stay in accum_ctrl.

Verification
REQ-032 Bench case, WIDTH=8, N=4: start, then operands 1,2,3,4 back-to-back -> q_ld=1 for one cycle, q_d=10, ovf=0, busy drops the cycle after q_ld.
REQ-033 Bench case: operands 200,100,0,0 -> q_d=44 and ovf=1 without ACCUM_SAT_EN; q_d=255 and ovf=1 with it.
REQ-034 Bench case: operands 5,6,7,8 with 3 idle in_valid=0 cycles between each -> q_d=26, and q_ld arrives one cycle after the last handshake.
REQ-035 Bench case: rst after 2 operands -> IDLE next cycle with q_d=0, no q_ld; a following run of 1,1,1,1 -> q_d=4.
REQ-036 Bench case: start pulsed during LOAD -> no effect on counter or sum; N=1 build with operand 9 -> q_d=9.
